// File: rtl/link_frame_arbiter.sv
// Round-robin sequencer for the 4-bit strobed master/slave checksum link.
// Sends a 16-bit payload as 4 nibbles plus an XOR checksum, then retries on NACK or timeout.
module link_frame_arbiter #(
  parameter int BAUD_DIV     = 5,
  parameter int MAX_RETRY    = 2,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic [15:0] m_payload,
  output logic        m_grant,
  output logic        m_done,
  output logic        m_err,
  input  logic        s_req,
  input  logic [15:0] s_payload,
  output logic        s_grant,
  output logic        s_done,
  output logic        s_err,
  output logic        link_dir,
  output logic        link_strobe,
  output logic [3:0]  link_data,
  input  logic        link_chk_vld,
  input  logic        link_chk_ok,
  output logic        busy
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CHK, ST_WAIT} state_t;

  state_t          r_state, w_state;
  logic [BW-1:0]   r_baud;
  logic [15:0]     r_frame, w_frame;
  logic [1:0]      r_idx, w_idx;
  logic [RW-1:0]   r_retry, w_retry;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic            r_own_m, w_own_m;
  logic            r_last_m, w_last_m;
  logic            r_m_grant, w_m_grant, r_s_grant, w_s_grant;
  logic            r_m_done, w_m_done, r_m_err, w_m_err;
  logic            r_s_done, w_s_done, r_s_err, w_s_err;
  logic            r_dir, w_dir;
  logic            r_strobe, w_strobe;
  logic [3:0]      r_data, w_data;
  logic            w_tick;
  logic [3:0]      w_nib;
  logic [3:0]      w_chk;

  assign w_tick = (r_baud == BAUD_LAST);
  assign w_chk  = r_frame[3:0] ^ r_frame[7:4] ^ r_frame[11:8] ^ r_frame[15:12];

  always_comb begin
    w_nib = r_frame[3:0];
    case (r_idx)
      2'd1:    w_nib = r_frame[7:4];
      2'd2:    w_nib = r_frame[11:8];
      2'd3:    w_nib = r_frame[15:12];
      default: w_nib = r_frame[3:0];
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_frame   = r_frame;
    w_idx     = r_idx;
    w_retry   = r_retry;
    w_tmo     = r_tmo;
    w_own_m   = r_own_m;
    w_last_m  = r_last_m;
    w_m_grant = r_m_grant;
    w_s_grant = r_s_grant;
    w_m_done  = 1'b0;
    w_m_err   = 1'b0;
    w_s_done  = 1'b0;
    w_s_err   = 1'b0;
    w_dir     = r_dir;
    w_strobe  = 1'b0;
    w_data    = r_data;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && (m_req || s_req)) begin
          // r_last_m resets to 0 (slave served last), so master wins the first tie
          w_own_m   = m_req && (!s_req || !r_last_m);
          w_frame   = w_own_m ? m_payload : s_payload;
          w_idx     = '0;
          w_retry   = '0;
          w_dir     = w_own_m;
          w_m_grant = w_own_m;
          w_s_grant = !w_own_m;
          w_state   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_tick) begin
          w_data   = w_nib;
          w_strobe = 1'b1;
          w_idx    = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_tick) begin
          w_data   = w_chk;
          w_strobe = 1'b1;
          w_tmo    = '0;
          w_state  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // an explicit verdict takes priority over a timeout expiring in the same cycle
        if (link_chk_vld && link_chk_ok) begin
          w_m_done  = r_own_m;
          w_s_done  = !r_own_m;
          w_m_grant = 1'b0;
          w_s_grant = 1'b0;
          w_last_m  = r_own_m;
          w_state   = ST_IDLE;
        end else if (link_chk_vld || (r_tmo == TMO_LAST)) begin
          if (r_retry < RETRY_MAX) begin
            w_retry = r_retry + 1'b1;
            w_idx   = '0;
            w_state = ST_SEND;
          end else begin
            w_m_err   = r_own_m;
            w_s_err   = !r_own_m;
            w_m_grant = 1'b0;
            w_s_grant = 1'b0;
            w_last_m  = r_own_m;
            w_state   = ST_IDLE;
          end
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_frame   <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_tmo     <= '0;
      r_own_m   <= 1'b0;
      r_last_m  <= 1'b0;
      r_m_grant <= 1'b0;
      r_s_grant <= 1'b0;
      r_m_done  <= 1'b0;
      r_m_err   <= 1'b0;
      r_s_done  <= 1'b0;
      r_s_err   <= 1'b0;
      r_dir     <= 1'b0;
      r_strobe  <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state;
      r_baud    <= w_tick ? '0 : r_baud + 1'b1;
      r_frame   <= w_frame;
      r_idx     <= w_idx;
      r_retry   <= w_retry;
      r_tmo     <= w_tmo;
      r_own_m   <= w_own_m;
      r_last_m  <= w_last_m;
      r_m_grant <= w_m_grant;
      r_s_grant <= w_s_grant;
      r_m_done  <= w_m_done;
      r_m_err   <= w_m_err;
      r_s_done  <= w_s_done;
      r_s_err   <= w_s_err;
      r_dir     <= w_dir;
      r_strobe  <= w_strobe;
      r_data    <= w_data;
    end
  end

  assign m_grant     = r_m_grant;
  assign s_grant     = r_s_grant;
  assign m_done      = r_m_done;
  assign m_err       = r_m_err;
  assign s_done      = r_s_done;
  assign s_err       = r_s_err;
  assign link_dir    = r_dir;
  assign link_strobe = r_strobe;
  assign link_data   = r_data;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_link_frame_arbiter.sv
// Bench for link_frame_arbiter: table of frame scenarios, nibble/result scoreboard,
// plus hand sequences for verdict-at-timeout, stray verdicts and mid-frame reset.
module tb_link_frame_arbiter;
  localparam int BAUD_DIV     = 5;
  localparam int MAX_RETRY    = 2;
  localparam int RESP_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_req = 1'b0, s_req = 1'b0;
  logic [15:0] m_payload = '0, s_payload = '0;
  logic        link_chk_vld = 1'b0, link_chk_ok = 1'b0;
  logic        m_grant, m_done, m_err, s_grant, s_done, s_err;
  logic        link_dir, link_strobe, busy;
  logic [3:0]  link_data;

  link_frame_arbiter #(.BAUD_DIV(BAUD_DIV), .MAX_RETRY(MAX_RETRY), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_payload(m_payload), .m_grant(m_grant), .m_done(m_done), .m_err(m_err),
    .s_req(s_req), .s_payload(s_payload), .s_grant(s_grant), .s_done(s_done), .s_err(s_err),
    .link_dir(link_dir), .link_strobe(link_strobe), .link_data(link_data),
    .link_chk_vld(link_chk_vld), .link_chk_ok(link_chk_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned ncyc;
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic dir; logic [3:0] data; } nib_t;
  nib_t       nq[$];
  logic [3:0] eq[$];

  typedef struct {
    bit mreq; bit sreq; logic [15:0] mpay; logic [15:0] spay;
    int nfail; bit use_tmo; bit drop; int lat;
    bit exp_m; bit exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event within bound", name);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] p, input int k);
    logic [15:0] s;
    s = p >> (4 * k);
    return s[3:0];
  endfunction

  function automatic logic [31:0] outs();
    return 32'({m_grant, m_done, m_err, s_grant, s_done, s_err,
                link_dir, link_strobe, link_data, busy});
  endfunction

  function automatic logic [3:0] pulses();
    return {m_done, m_err, s_done, s_err};
  endfunction

  function automatic vec_t mk(bit mr, bit sr, logic [15:0] mp, logic [15:0] sp, int nf,
                              bit tmo, bit dr, int lat, bit em, bit ee);
    vec_t v;
    v.mreq = mr; v.sreq = sr; v.mpay = mp; v.spay = sp; v.nfail = nf;
    v.use_tmo = tmo; v.drop = dr; v.lat = lat; v.exp_m = em; v.exp_err = ee;
    return v;
  endfunction

  task automatic push_frame(input logic [15:0] p, input logic dir, input int attempts);
    for (int a = 0; a < attempts; a++) begin
      for (int k = 0; k < 4; k++) nq.push_back({dir, nib(p, k)});
      nq.push_back({dir, nib(p, 0) ^ nib(p, 1) ^ nib(p, 2) ^ nib(p, 3)});
    end
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_grant || s_grant) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) note_fail("grant_wait");
  endtask

  task automatic wait_strobes(input int n, output bit got);
    int cnt;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (link_strobe) cnt++;
      if (cnt == n) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) note_fail("strobe_wait");
  endtask

  // Scoreboard / invariant monitor
  always @(negedge clk) begin
    nib_t       e;
    logic [3:0] pul;
    logic [3:0] ev;
    if (!rst) begin
      chk("grant_overlap", 32'(m_grant & s_grant), 32'd0);
      if (link_strobe) begin
        chk("strobe_phase", ncyc % BAUD_DIV, 32'd0);
        chk("strobe_busy", 32'(busy), 32'd1);
        if (nq.size() == 0) begin
          note_fail("unexpected_strobe");
        end else begin
          e = nq.pop_front();
          chk("link_data", 32'(link_data), 32'(e.data));
          chk("link_dir", 32'(link_dir), 32'(e.dir));
        end
      end
      pul = pulses();
      if (pul != 4'd0) begin
        chk("pulse_exclusive", 32'($countones(pul)), 32'd1);
        if (eq.size() == 0) begin
          note_fail("unexpected_result_pulse");
        end else begin
          ev = eq.pop_front();
          chk("result_pulse", 32'(pul), 32'(ev));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    bit         got;
    int         natt;
    bit         fail_now, last;
    logic [3:0] fpul, want;
    m_req = v.mreq; s_req = v.sreq; m_payload = v.mpay; s_payload = v.spay;
    wait_grant(got);
    if (!got) return;
    chk("grant_owner", 32'({m_grant, s_grant}), v.exp_m ? 32'd2 : 32'd1);
    chk("grant_dir", 32'(link_dir), 32'(v.exp_m));
    chk("grant_phase", ncyc % BAUD_DIV, 32'd0);
    natt = (v.nfail > MAX_RETRY) ? MAX_RETRY + 1 : v.nfail + 1;
    fpul = v.exp_m ? (v.exp_err ? 4'b0100 : 4'b1000) : (v.exp_err ? 4'b0001 : 4'b0010);
    push_frame(v.exp_m ? v.mpay : v.spay, v.exp_m, natt);
    eq.push_back(fpul);
    if (v.drop) begin
      m_req = 1'b0;
      s_req = 1'b0;
    end
    m_payload = ~m_payload;
    s_payload = s_payload ^ 16'h5555;
    for (int a = 0; a < natt; a++) begin
      wait_strobes(5, got);
      if (!got) return;
      fail_now = (a < v.nfail);
      last     = (a == natt - 1);
      want     = last ? fpul : 4'd0;
      if (fail_now && v.use_tmo) begin
        repeat (RESP_TIMEOUT) @(negedge clk);
        chk("timeout_result", 32'(pulses()), 32'(want));
      end else begin
        repeat (v.lat) @(negedge clk);
        link_chk_vld = 1'b1;
        link_chk_ok  = !fail_now;
        @(negedge clk);
        link_chk_vld = 1'b0;
        link_chk_ok  = 1'b0;
        chk("verdict_result", 32'(pulses()), 32'(want));
      end
      if (!last) chk("retry_busy", 32'(busy), 32'd1);
    end
    chk("grant_drop", 32'({m_grant, s_grant}), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    m_req = 1'b0;
    s_req = 1'b0;
  endtask

  vec_t vt[9];

  initial begin
    bit got;
    int c0;
    vt[0] = mk(1, 1, 16'h3C96, 16'h7E01, 0, 0, 0, 2,  1, 0);
    vt[1] = mk(1, 1, 16'h0F0F, 16'hBEEF, 0, 0, 0, 0,  0, 0);
    vt[2] = mk(1, 1, 16'h1357, 16'h2468, 0, 0, 0, 5,  1, 0);
    vt[3] = mk(1, 0, 16'hA35C, 16'h0000, 0, 0, 0, 1,  1, 0);
    vt[4] = mk(1, 0, 16'hC0DE, 16'h0000, 2, 0, 1, 3,  1, 0);
    vt[5] = mk(0, 1, 16'h0000, 16'h9ABC, 3, 1, 0, 0,  0, 1);
    vt[6] = mk(1, 0, 16'h4D2B, 16'h0000, 3, 0, 1, 7,  1, 1);
    vt[7] = mk(0, 1, 16'h0000, 16'hF00D, 1, 1, 0, 15, 0, 0);
    vt[8] = mk(1, 1, 16'h8421, 16'h1248, 0, 0, 1, 4,  1, 0);

    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Stray verdicts in IDLE and SEND, then a verdict exactly at timeout expiry
    @(negedge clk);
    link_chk_vld = 1'b1; link_chk_ok = 1'b1;
    @(negedge clk);
    link_chk_vld = 1'b0; link_chk_ok = 1'b0;
    chk("idle_verdict_busy", 32'(busy), 32'd0);
    m_req = 1'b1; m_payload = 16'h0F1E;
    wait_grant(got);
    if (got) begin
      push_frame(16'h0F1E, 1'b1, 1);
      eq.push_back(4'b1000);
      m_req = 1'b0;
      wait_strobes(1, got);
      link_chk_vld = 1'b1; link_chk_ok = 1'b1;
      @(negedge clk);
      link_chk_ok = 1'b0;
      @(negedge clk);
      link_chk_vld = 1'b0;
      chk("send_verdict_ignored", 32'(pulses()), 32'd0);
      wait_strobes(4, got);
      c0 = int'(ncyc);
      repeat (RESP_TIMEOUT - 1) @(negedge clk);
      link_chk_vld = 1'b1; link_chk_ok = 1'b1;
      @(negedge clk);
      link_chk_vld = 1'b0; link_chk_ok = 1'b0;
      chk("verdict_at_timeout", 32'(pulses()), 32'b1000);
      chk("verdict_at_timeout_cyc", 32'(int'(ncyc) - c0), 32'(RESP_TIMEOUT));
      chk("verdict_at_timeout_busy", 32'(busy), 32'd0);
    end

    // Reset after the 2nd nibble strobe aborts the frame silently
    m_req = 1'b1; m_payload = 16'h1234;
    wait_grant(got);
    if (got) begin
      push_frame(16'h1234, 1'b1, 1);
      wait_strobes(2, got);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_async_outputs", outs(), 32'd0);
      m_req = 1'b0;
      nq.delete();
      eq.delete();
      repeat (2) @(negedge clk);
      chk("rst_hold_outputs", outs(), 32'd0);
      s_req = 1'b1; s_payload = 16'h5A5A;
      rst = 1'b0;
      wait_grant(got);
      if (got) begin
        chk("rst_first_grant_cyc", ncyc, 32'(BAUD_DIV));
        chk("rst_grant_owner", 32'({m_grant, s_grant}), 32'd1);
        chk("rst_grant_dir", 32'(link_dir), 32'd0);
        push_frame(16'h5A5A, 1'b0, 1);
        eq.push_back(4'b0010);
        s_req = 1'b0;
        wait_strobes(5, got);
        repeat (2) @(negedge clk);
        link_chk_vld = 1'b1; link_chk_ok = 1'b1;
        @(negedge clk);
        link_chk_vld = 1'b0; link_chk_ok = 1'b0;
        chk("rst_new_frame_done", 32'(pulses()), 32'b0010);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_nibbles_left", 32'(nq.size()), 32'd0);
    chk("sb_results_left", 32'(eq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/link_frame_arbiter.md
Name: link_frame_arbiter

Overview:
- Sequencer and arbiter for the 4-bit strobed master/slave checksum link.
- Two requesters, master side and slave side, each offer a 16-bit payload. The block grants the link to one requester round-robin and drives direction, strobe and data nibble-by-nibble on a baud tick.
- After the data it appends the column-XOR checksum nibble, waits for the receiver's verdict, and retries on failure or timeout.

Parameters:
BAUD_DIV, 5, clk cycles per baud tick (>=2)
MAX_RETRY, 2, resends allowed after the first attempt before reporting error
RESP_TIMEOUT, 16, clk cycles to wait in WAIT for a verdict

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m_req  in  1  master-side requester wants to send
m_payload  in  16  master payload, sampled at grant
m_grant  out  1  master owns the link
m_done  out  1  1-cycle pulse: master frame accepted
m_err  out  1  1-cycle pulse: master frame failed after all retries
s_req  in  1  slave-side requester wants to send
s_payload  in  16  slave payload, sampled at grant
s_grant  out  1  slave owns the link
s_done  out  1  1-cycle pulse: slave frame accepted
s_err  out  1  1-cycle pulse: slave frame failed
link_dir  out  1  1 = master->slave, 0 = slave->master
link_strobe  out  1  1-cycle pulse: link_data valid
link_data  out  4  nibble on the link
link_chk_vld  in  1  receiver verdict strobe
link_chk_ok  in  1  verdict, qualified by link_chk_vld
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; baud counter 0; retry count 0; rr pointer = slave, so master wins the first tie.
- Baud counter:
  - Free-running 0..BAUD_DIV-1.
  - tick is an internal 1-cycle pulse in the cycle the counter wraps.
  - First tick occurs BAUD_DIV cycles after reset release.
- States: IDLE, SEND, CHK, WAIT.
- IDLE:
  - On tick with m_req or s_req, grant one requester. If both request, grant the one not served last; if one requests, grant it.
  - Latch its payload into the frame register, clear nibble index and retry count, set link_dir (1 for master, 0 for slave), assert the grant, go to SEND.
  - Requests without a tick wait.
- SEND:
  - On each tick: link_data = payload nibble[idx], link_strobe = 1 for that cycle, idx++.
  - Nibble order is [3:0], [7:4], [11:8], [15:12].
  - After the 4th nibble, go to CHK.
- CHK:
  - On the next tick: link_data = n0^n1^n2^n3 (bitwise), link_strobe = 1.
  - Clear the timeout counter, go to WAIT.
- WAIT:
  - link_chk_vld && link_chk_ok: pulse done of the owner, drop the grant the same cycle, set rr pointer = owner, go to IDLE.
  - link_chk_vld && !link_chk_ok, or timeout counter reaches RESP_TIMEOUT: this is a failure.
    - If retry count < MAX_RETRY: retry++, idx = 0, go to SEND. The frame register is unchanged.
    - Else: pulse err of the owner, drop the grant, set rr pointer = owner, go to IDLE.
  - A verdict in the same cycle as timeout expiry: the verdict wins.
- Frame lifetime:
  - link_dir and the grant are held constant for the whole frame, including retries.
  - link_dir keeps its last value in IDLE.
  - link_data keeps its last value between strobes.
- Ignored inputs:
  - Requester dropping req mid-frame: ignored, the frame completes.
  - Payload changes after grant: ignored.
  - link_chk_vld outside WAIT: ignored.
- Latency:
  - Grant appears the cycle after the IDLE tick.
  - Nibble k strobes on tick k+1 after grant; checksum on tick 5.
  - Minimum frame is 5*BAUD_DIV cycles plus verdict latency.
- Invariants:
  - Done and err are never asserted together.
  - At most one grant is high.
  - link_strobe only in SEND/CHK.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No done/err pulse for the aborted frame.

Test Plan:
1. Single master: m_payload=16'hA35C, verdict ok=1 in WAIT -> m_grant=1, link_dir=1, strobes C,5,3,A then checksum C^5^3^A=0; one m_done pulse; m_grant drops.
2. Simultaneous m_req and s_req after reset, both held -> master served first, then slave (link_dir=0), then master; grants never overlap.
3. Verdict ok=0 twice, then ok=1 -> frame resent 3 times with identical nibbles; m_done once, no m_err.
4. No verdict ever, MAX_RETRY=2, RESP_TIMEOUT=16 -> 3 full frames each followed by 16 idle WAIT cycles; single s_err; grant released; busy=0.
5. rst pulsed after the 2nd nibble strobe -> all outputs 0 immediately, no done/err; first tick BAUD_DIV cycles after release; a new request is served cleanly.
6. link_chk_vld=1 in the exact cycle the timeout expires, ok=1 -> done (not retry); link_chk_vld pulsed during SEND -> no effect.
